// File: rtl/fixed_point_pkg.sv
// Shared types for the 16-bit fixed-point adder and its request arbiter.
package fixed_point_pkg;

    localparam int DATA_W   = 16;
    // Widest requester ID the arbiter supports (N_REQ up to 8).
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
    } add_op_t;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [DATA_W-1:0]   result;
        logic                cout;
        logic                overflow;
        logic                negative;
    } add_resp_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } resp_state_t;

endpackage

// File: rtl/adder.sv
// Combinational 16-bit adder with carry, signed overflow and sign flags.
module adder
    import fixed_point_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              overflow_flag,
    output logic              negative
);

    logic [DATA_W:0] sum;

    assign sum           = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    assign result        = sum[DATA_W-1:0];
    assign cout          = sum[DATA_W];
    // Overflow only when both operands share a sign the result does not.
    assign overflow_flag = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    assign negative      = sum[DATA_W-1];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among N_REQ requesters, with a
// single registered response slot that supports drain-and-refill per cycle.
module adder_arbiter
    import fixed_point_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [DATA_W*N_REQ-1:0] req_a,
    input  logic [DATA_W*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]        req_cin,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [DATA_W-1:0]       resp_result,
    output logic                    resp_cout,
    output logic                    resp_overflow,
    output logic                    resp_negative
);

    resp_state_t       state_q, state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     pos;
    logic              grant_found;
    logic              can_accept;
    logic              transfer;
    add_op_t           op;
    add_resp_t         resp_q, resp_d;
    logic [DATA_W-1:0] sum;
    logic              sum_cout, sum_ovf, sum_neg;

    assign resp_valid = (state_q == FULL);
    // Free slot, or the current result leaves this same cycle.
    assign can_accept = (state_q == EMPTY) || (resp_valid && resp_ready);
    assign transfer   = |req_ready;

    // Find the first valid requester starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(N_REQ)) pos = pos - (ID_W+1)'(N_REQ);
            if (!grant_found && req_valid[pos[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = pos[ID_W-1:0];
            end
        end
    end

    // One-hot ready to the granted requester; held low during reset.
    always_comb begin
        req_ready = '0;
        if (!rst && can_accept && grant_found) req_ready[grant_idx] = 1'b1;
    end

    // Steer the granted requester's operands into the shared adder.
    always_comb begin
        op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                op.a   = req_a[i*DATA_W +: DATA_W];
                op.b   = req_b[i*DATA_W +: DATA_W];
                op.cin = req_cin[i];
            end
        end
    end

    adder u_adder (op.a, op.b, op.cin, sum, sum_cout, sum_ovf, sum_neg);

    // Pack adder outputs and the winner's ID for the response register.
    always_comb begin
        resp_d          = '0;
        resp_d.id       = MAX_ID_W'(grant_idx);
        resp_d.result   = sum;
        resp_d.cout     = sum_cout;
        resp_d.overflow = sum_ovf;
        resp_d.negative = sum_neg;
    end

    // Response slot occupancy: refill keeps it FULL, a bare drain empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (transfer) state_d = FULL;
            FULL:    if (transfer) state_d = FULL;
                     else if (resp_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // State, round-robin pointer and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            rr_ptr  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            if (transfer) begin
                resp_q <= resp_d;
                rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
        end
    end

    assign resp_id       = resp_q.id[ID_W-1:0];
    assign resp_result   = resp_q.result;
    assign resp_cout     = resp_q.cout;
    assign resp_overflow = resp_q.overflow;
    assign resp_negative = resp_q.negative;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a reference arbiter model predicts
// req_ready and queues expected responses; responses are compared on output.
module tb_adder_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_a, req_b;
    logic [N-1:0]    req_cin;
    logic            resp_valid, resp_ready;
    logic [1:0]      resp_id;
    logic [15:0]     resp_result;
    logic            resp_cout, resp_overflow, resp_negative;

    int n_chk = 0;
    int n_err = 0;

    // Model state: round-robin pointer, slot occupancy, expected responses.
    int          m_ptr  = 0;
    logic        m_full = 1'b0;
    logic [21:0] sb[$];

    always #5 clk = ~clk;

    adder_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result), .resp_cout(resp_cout),
        .resp_overflow(resp_overflow), .resp_negative(resp_negative)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected response word {id, cout, overflow, negative, result}.
    function automatic logic [21:0] model(input logic [2:0] id, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        logic [16:0] s;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + {16'd0, c};
        v = (a[15] == b[15]) && (s[15] != a[15]);
        return {id, s[16], v, s[15], s[15:0]};
    endfunction

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_cin[i]        = c;
        req_valid[i]      = 1'b1;
    endtask

    // Called at a falling edge after inputs are set; checks, advances model, runs one clock.
    task automatic tick();
        logic [N-1:0] er;
        logic [1:0]   gi, jj;
        logic         found;
        #1;
        er    = '0;
        gi    = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            jj = 2'((m_ptr + k) % N);
            if (!found && req_valid[jj]) begin
                found = 1'b1;
                gi    = jj;
            end
        end
        if (!rst && found && (!m_full || resp_ready)) er[gi] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("resp_valid", 32'(resp_valid), 32'(m_full));
        if (m_full && sb.size() > 0) begin
            chk("resp", 32'({1'b0, resp_id, resp_cout, resp_overflow, resp_negative, resp_result}),
                32'(sb[0]));
            if (resp_ready && !rst) void'(sb.pop_front());
        end
        if (rst) begin
            sb.delete();
            m_full = 1'b0;
            m_ptr  = 0;
        end else begin
            if (|er) begin
                sb.push_back(model({1'b0, gi}, req_a[gi*16 +: 16], req_b[gi*16 +: 16], req_cin[gi]));
                m_ptr  = (int'(gi) + 1) % N;
                m_full = 1'b1;
            end else if (m_full && resp_ready) begin
                m_full = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("rst_valid",  32'(resp_valid),  32'd0);
        chk("rst_result", 32'(resp_result), 32'd0);
        chk("rst_flags",  32'({resp_id, resp_cout, resp_overflow, resp_negative}), 32'd0);
        rst = 1'b0;
        tick();

        // Single op on requester 0: positive overflow into the sign bit.
        set_req(0, 16'h7FFF, 16'h0001, 1'b0);
        tick();
        req_valid = '0;
        chk("single_id",  32'(resp_id), 32'd0);
        chk("single_res", 32'(resp_result), 32'h8000);
        chk("single_flg", 32'({resp_cout, resp_overflow, resp_negative}), 32'b011);
        tick();

        // Carry wrap on requester 2.
        set_req(2, 16'hFFFF, 16'h0000, 1'b1);
        tick();
        req_valid = '0;
        chk("wrap_id",  32'(resp_id), 32'd2);
        chk("wrap_res", 32'(resp_result), 32'h0000);
        chk("wrap_flg", 32'({resp_cout, resp_overflow, resp_negative}), 32'b100);
        tick();

        // Signed mix on requester 1: negative overflow to positive.
        set_req(1, 16'h8000, 16'hFFFF, 1'b0);
        tick();
        req_valid = '0;
        chk("mix_res", 32'(resp_result), 32'h7FFF);
        chk("mix_flg", 32'({resp_cout, resp_overflow, resp_negative}), 32'b110);
        tick();

        // Round-robin from a fresh reset: all valid, grants 0,1,2,3,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 16'(i * 16'h1111), 16'(16'h0100 + i), 1'(i));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_id", 32'(resp_id), 32'(i % N));
        end
        req_valid = '0;
        tick();

        // Backpressure: result from requester 3 held while requester 1 waits.
        resp_ready = 1'b0;
        set_req(3, 16'h1234, 16'h4321, 1'b0);
        tick();
        req_valid = '0;
        set_req(1, 16'hAAAA, 16'h5555, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_res",   32'(resp_result), 32'h5555);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_accept", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk("bp_id",  32'(resp_id), 32'd1);
        chk("bp_res1", 32'(resp_result), 32'h0000);
        chk("bp_cout", 32'(resp_cout), 32'd1);

        // Reset while a response is pending, then requester 0 wins over 3.
        resp_ready = 1'b0;
        rst = 1'b1;
        set_req(3, 16'h0003, 16'h0004, 1'b0);
        set_req(0, 16'h0010, 16'h0020, 1'b0);
        tick();
        chk("rmid_valid", 32'(resp_valid), 32'd0);
        chk("rmid_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("rmid_grant", 32'(req_ready), 32'b0001);
        tick();
        chk("rmid_res", 32'(resp_result), 32'h0030);

        // Random traffic, including valids that drop without a transfer.
        for (int i = 0; i < 300; i++) begin
            req_valid  = 4'($urandom_range(0, 15));
            req_a      = {$urandom(), $urandom()};
            req_b      = {$urandom(), $urandom()};
            req_cin    = 4'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
